console_cursor_ctrl: RTL
========================

// Module: console_cursor_ctrl
// PURPOSE
//  Terminal-style write sequencer for the VGA text console's character buffer.
//  Accepts a byte stream through a valid/ready handshake and tracks a cursor.
//  Writes printable glyphs at the cursor and performs wrap, newline, backspace,
//  clear-screen and scroll by sequencing the buffer's read/write ports.
//  Sits between the host register interface and the text buffer inside the peripheral.
// PARAMETERS
//  NUM_ROWS  3     text rows in the buffer
//  NUM_COLS  10    text columns per row
//  ADDR_W    5     buffer address width; must satisfy 2**ADDR_W >= NUM_ROWS*NUM_COLS
//  BLANK_CH  8'h20 fill byte for cleared cells (space, color bit 0)
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       reset: synchronous, active-low
//  char_valid  in   1       host byte available
//  char_data   in   8       {color_sel, 7-bit code}
//  char_ready  out  1       byte accepted when char_valid & char_ready
//  vblank      in   1       high during vertical blanking (from the timing generator)
//  buf_raddr   out  ADDR_W  buffer read address; buffer read is asynchronous
//  buf_rdata   in   8       buffer read data for buf_raddr, same cycle
//  buf_we      out  1       buffer write strobe; takes priority over host writes
//  buf_waddr   out  ADDR_W  buffer write address
//  buf_wdata   out  8       buffer write data
//  cur_row     out  2       cursor row, 0..NUM_ROWS-1
//  cur_col     out  4       cursor column, 0..NUM_COLS-1
//  busy        out  1       high when state != IDLE
// BEHAVIOUR
//  - Reset values: state IDLE, cur_row=0, cur_col=0, buf_we=0, buf_waddr=0, buf_wdata=0.
//    char_ready is 1 out of reset. Buffer contents are not touched by reset.
//  - Reset mid-scroll or mid-clear aborts immediately. Partially moved rows remain as written.
//  - char_ready = (state==IDLE). Exactly one byte is accepted per handshake.
//  - All buf_* outputs are registered. A write appears on the cycle after its decision.
//  - Decoding uses code = char_data[6:0]; c = char_data[7]:
//    * 0x20..0x7E: go to PUT.
//      - PUT cycle: buf_we=1, waddr=cur_row*NUM_COLS+cur_col, wdata={c,code}.
//      - Then advance cur_col. If cur_col==NUM_COLS-1: cur_col=0, then newline.
//    * 0x0A (LF): cur_col=0, then newline. No write.
//    * 0x0D (CR): cur_col=0. No write. Returns to IDLE next cycle.
//    * 0x08 (BS): cur_col decrements and saturates at 0. No write. No row change.
//    * 0x0C (FF): go to CLEAR_ALL. When done: cur_row=0, cur_col=0.
//    * any other code: consumed; one non-ready cycle; no effect.
//  - Newline:
//    * if cur_row < NUM_ROWS-1: cur_row+1.
//    * otherwise go to SCROLL; cur_row stays NUM_ROWS-1.
//  - SCROLL:
//    * Index i runs 0..(NUM_ROWS-1)*NUM_COLS-1, one cell per cycle.
//    * raddr=i+NUM_COLS; write waddr=i, wdata=buf_rdata (write lands the next cycle).
//    * Then go to CLEAR_LINE.
//  - CLEAR_LINE: writes BLANK_CH to the last row, NUM_COLS cycles.
//  - CLEAR_ALL: writes BLANK_CH to cells 0..NUM_ROWS*NUM_COLS-1, one per cycle.
//  - Scroll plus clear takes NUM_ROWS*NUM_COLS write cycles (30 at defaults).
//    FF takes the same count.
//  - State set: IDLE, PUT, CTRL (1-cycle consume), WAIT_VB, SCROLL, CLEAR_LINE, CLEAR_ALL.
//  - Cell counters never exceed NUM_ROWS*NUM_COLS-1. Address arithmetic is ADDR_W bits.
//  - A wrap and a scroll caused by the same PUT happen back-to-back, with no idle cycle.
// CONFIGURATION
//  CONSOLE_VBLANK_SYNC_EN defined:
//    - SCROLL and CLEAR_ALL first enter WAIT_VB and leave it on the first cycle
//      with vblank=1.
//    - Once started, they run to completion even if vblank falls.
//    - PUT, CR, LF (no scroll) and BS never wait.
//  CONSOLE_VBLANK_SYNC_EN undefined: WAIT_VB is absent, vblank is ignored,
//    and sequences start on the next cycle.
// TESTING
//  1. Reset, send 'A'(0x41), then 0xC2.
//     -> cell0=0x41, cell1=0xC2, cursor(0,2), char_ready low 1 cycle per byte.
//  2. Send 10 printable bytes at cursor (1,0).
//     -> cells 10..19 written; cursor(2,0); no scroll.
//  3. Cursor (2,5), rows preloaded with 0x30/0x31/0x32; send LF.
//     -> cells 0..9=0x31, 10..19=0x32, 20..29=0x20, cursor(2,0), busy for 30 cycles.
//  4. Cursor (1,0) send BS -> (1,0).
//     Cursor (1,3) send BS -> (1,2).
//     Send CR -> (1,0). No buf_we in any of these.
//  5. Send FF -> all 30 cells=0x20, cursor(0,0).
//     With CONSOLE_VBLANK_SYNC_EN and vblank=0: no writes until vblank rises.
//  6. Assert rst_n=0 at write 12 of a scroll.
//     -> next cycle buf_we=0, cursor(0,0), char_ready=1.

Source files
------------

// File: rtl/console_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : console_cursor_ctrl
// Description : Terminal-style write sequencer for the text console buffer:
//               glyph put, wrap, LF/CR/BS, form-feed clear and scroll.
//               Optional macro CONSOLE_VBLANK_SYNC_EN holds scroll/clear
//               until vertical blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module console_cursor_ctrl #(
    parameter int             NUM_ROWS = 3,
    parameter int             NUM_COLS = 10,
    parameter int             ADDR_W   = 5,
    parameter logic [7:0]     BLANK_CH = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    input  logic              vblank,
    output logic [ADDR_W-1:0] buf_raddr,
    input  logic [7:0]        buf_rdata,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [7:0]        buf_wdata,
    output logic [1:0]        cur_row,
    output logic [3:0]        cur_col,
    output logic              busy
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_PUT        = 3'd1;
    localparam logic [2:0] S_CTRL       = 3'd2;
    localparam logic [2:0] S_SCROLL     = 3'd4;
    localparam logic [2:0] S_CLEAR_LINE = 3'd5;
    localparam logic [2:0] S_CLEAR_ALL  = 3'd6;

`ifdef CONSOLE_VBLANK_SYNC_EN
    localparam logic [2:0] S_WAIT_VB    = 3'd3;
    localparam logic [2:0] S_SCROLL_ENT = S_WAIT_VB;
    localparam logic [2:0] S_CLEAR_ENT  = S_WAIT_VB;
`else
    localparam logic [2:0] S_SCROLL_ENT = S_SCROLL;
    localparam logic [2:0] S_CLEAR_ENT  = S_CLEAR_ALL;
`endif

    localparam logic [ADDR_W-1:0] C_COLS          = ADDR_W'(NUM_COLS);
    localparam logic [ADDR_W-1:0] C_LAST_CELL     = ADDR_W'(NUM_ROWS*NUM_COLS-1);
    localparam logic [ADDR_W-1:0] C_SCROLL_LAST   = ADDR_W'((NUM_ROWS-1)*NUM_COLS-1);
    localparam logic [ADDR_W-1:0] C_LAST_ROW_BASE = ADDR_W'((NUM_ROWS-1)*NUM_COLS);
    localparam logic [ADDR_W-1:0] C_LAST_COL_IDX  = ADDR_W'(NUM_COLS-1);
    localparam logic [1:0]        C_LAST_ROW      = 2'(NUM_ROWS-1);
    localparam logic [3:0]        C_LAST_COL      = 4'(NUM_COLS-1);

    localparam logic [6:0] C_LF = 7'h0A;
    localparam logic [6:0] C_CR = 7'h0D;
    localparam logic [6:0] C_BS = 7'h08;
    localparam logic [6:0] C_FF = 7'h0C;

    logic [2:0]        state_q, state_d;
    logic [1:0]        cur_row_q, cur_row_d;
    logic [3:0]        cur_col_q, cur_col_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] buf_raddr_q, buf_raddr_d;
    logic              buf_we_q, buf_we_d;
    logic [ADDR_W-1:0] buf_waddr_q, buf_waddr_d;
    logic [7:0]        buf_wdata_q, buf_wdata_d;
    logic [6:0]        code;
    logic [ADDR_W-1:0] cur_addr;

`ifdef CONSOLE_VBLANK_SYNC_EN
    logic              pend_clear_q, pend_clear_d;
`else
    logic              unused_vblank;
    assign unused_vblank = vblank;
`endif

    assign code     = char_data[6:0];
    assign cur_addr = ADDR_W'(cur_row_q) * C_COLS + ADDR_W'(cur_col_q);

    always_comb begin
        state_d     = state_q;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;
        idx_d       = idx_q;
        buf_we_d    = 1'b0;
        buf_waddr_d = buf_waddr_q;
        buf_wdata_d = buf_wdata_q;
`ifdef CONSOLE_VBLANK_SYNC_EN
        pend_clear_d = pend_clear_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (char_valid) begin
                    if (code >= 7'h20 && code <= 7'h7E) begin
                        state_d     = S_PUT;
                        buf_we_d    = 1'b1;
                        buf_waddr_d = cur_addr;
                        buf_wdata_d = char_data;
                    end else if (code == C_LF) begin
                        cur_col_d = 4'd0;
                        if (cur_row_q == C_LAST_ROW) begin
                            state_d = S_SCROLL_ENT;
                            idx_d   = '0;
`ifdef CONSOLE_VBLANK_SYNC_EN
                            pend_clear_d = 1'b0;
`endif
                        end else begin
                            cur_row_d = cur_row_q + 2'd1;
                            state_d   = S_CTRL;
                        end
                    end else if (code == C_FF) begin
                        state_d = S_CLEAR_ENT;
                        idx_d   = '0;
`ifdef CONSOLE_VBLANK_SYNC_EN
                        pend_clear_d = 1'b1;
`endif
                    end else begin
                        state_d = S_CTRL;
                        if (code == C_CR) begin
                            cur_col_d = 4'd0;
                        end else if (code == C_BS && cur_col_q != 4'd0) begin
                            cur_col_d = cur_col_q - 4'd1;
                        end
                    end
                end
            end
            S_PUT: begin
                if (cur_col_q == C_LAST_COL) begin
                    cur_col_d = 4'd0;
                    if (cur_row_q == C_LAST_ROW) begin
                        // Wrap on the bottom row chains straight into the scroll.
                        state_d = S_SCROLL_ENT;
                        idx_d   = '0;
`ifdef CONSOLE_VBLANK_SYNC_EN
                        pend_clear_d = 1'b0;
`endif
                    end else begin
                        cur_row_d = cur_row_q + 2'd1;
                        state_d   = S_IDLE;
                    end
                end else begin
                    cur_col_d = cur_col_q + 4'd1;
                    state_d   = S_IDLE;
                end
            end
            S_CTRL: state_d = S_IDLE;
`ifdef CONSOLE_VBLANK_SYNC_EN
            S_WAIT_VB: begin
                if (vblank) begin
                    state_d = pend_clear_q ? S_CLEAR_ALL : S_SCROLL;
                end
            end
`endif
            S_SCROLL: begin
                buf_we_d    = 1'b1;
                buf_waddr_d = idx_q;
                buf_wdata_d = buf_rdata;
                if (idx_q == C_SCROLL_LAST) begin
                    idx_d   = '0;
                    state_d = S_CLEAR_LINE;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            S_CLEAR_LINE: begin
                buf_we_d    = 1'b1;
                buf_waddr_d = C_LAST_ROW_BASE + idx_q;
                buf_wdata_d = BLANK_CH;
                if (idx_q == C_LAST_COL_IDX) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            S_CLEAR_ALL: begin
                buf_we_d    = 1'b1;
                buf_waddr_d = idx_q;
                buf_wdata_d = BLANK_CH;
                if (idx_q == C_LAST_CELL) begin
                    idx_d     = '0;
                    cur_row_d = 2'd0;
                    cur_col_d = 4'd0;
                    state_d   = S_IDLE;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read address is registered, so it is presented one cycle ahead of the
    // scroll step that consumes the asynchronous read data.
    assign buf_raddr_d = (state_d == S_SCROLL) ? (idx_d + C_COLS) : buf_raddr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_row_q   <= 2'd0;
            cur_col_q   <= 4'd0;
            idx_q       <= '0;
            buf_raddr_q <= '0;
            buf_we_q    <= 1'b0;
            buf_waddr_q <= '0;
            buf_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
            idx_q       <= idx_d;
            buf_raddr_q <= buf_raddr_d;
            buf_we_q    <= buf_we_d;
            buf_waddr_q <= buf_waddr_d;
            buf_wdata_q <= buf_wdata_d;
        end
    end

`ifdef CONSOLE_VBLANK_SYNC_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_clear_q <= 1'b0;
        end else begin
            pend_clear_q <= pend_clear_d;
        end
    end
`endif

    assign char_ready = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign buf_raddr  = buf_raddr_q;
    assign buf_we     = buf_we_q;
    assign buf_waddr  = buf_waddr_q;
    assign buf_wdata  = buf_wdata_q;
    assign cur_row    = cur_row_q;
    assign cur_col    = cur_col_q;

endmodule
`default_nettype wire
